jpeg_block_serializer: RTL

JPEG_BLOCK_SERIALIZER -- requirements
Module: jpeg_block_serializer

---
 rtl/jpeg_block_serializer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/jpeg_block_serializer.sv
// Buffers NUM_CH-channel quantized block sets and serializes them one block per
// handshake. In subsampled mode, chroma is emitted only on every CHROMA_DIV-th set.
module jpeg_block_serializer #(
  parameter int unsigned BLK_W      = 640,
  parameter int unsigned NUM_CH     = 3,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned CHROMA_DIV = 4
) (
  input  logic                                             clk,
  input  logic                                             reset,
  input  logic                                             in_valid,
  output logic                                             in_ready,
  input  logic [NUM_CH*BLK_W-1:0]                          in_data,
  input  logic                                             in_last,
  input  logic                                             chroma_mode,
  output logic                                             out_valid,
  input  logic                                             out_ready,
  output logic [BLK_W-1:0]                                 out_data,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0]   out_ch,
  output logic                                             out_last,
  output logic [15:0]                                      blk_count
);

  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned IDX_W = (CHROMA_DIV > 1) ? $clog2(CHROMA_DIV) : 1;

  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CHROMA_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_EMIT  = 1'b1;

  logic [NUM_CH*BLK_W-1:0] mem_data_q [DEPTH];
  logic [DEPTH-1:0]        mem_last_q;
  logic [DEPTH-1:0]        mem_skip_q;

  logic [0:0]       state_q,     state_d;
  logic [PTR_W-1:0] wr_ptr_q,    wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q,    rd_ptr_d;
  logic [CNT_W-1:0] count_q,     count_d;
  logic [IDX_W-1:0] set_idx_q,   set_idx_d;
  logic [CH_W-1:0]  out_ch_q,    out_ch_d;
  logic [15:0]      blk_count_q, blk_count_d;
  logic             in_ready_q,  in_ready_d;

  logic push, pop, xfer;
  logic head_skip, head_last, last_ch, wr_skip;

  always_comb begin
    push      = in_valid && in_ready_q;
    head_skip = mem_skip_q[rd_ptr_q];
    head_last = mem_last_q[rd_ptr_q];
    out_valid = (state_q == ST_EMIT);
    // A skipped set ends after its Y block; otherwise after the last chroma channel.
    last_ch   = head_skip ? (out_ch_q == '0) : (out_ch_q == CH_LAST);
    xfer      = out_valid && out_ready;
    pop       = xfer && last_ch;
    out_last  = out_valid && head_last && last_ch;
    wr_skip   = chroma_mode && (set_idx_q != IDX_LAST);
  end

  always_comb begin
    out_data = '0;
    if (out_valid) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (out_ch_q == CH_W'(c)) begin
          out_data = mem_data_q[rd_ptr_q][c*BLK_W +: BLK_W];
        end
      end
    end
  end

  always_comb begin
    wr_ptr_d    = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d    = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
    in_ready_d  = (count_d < CNT_FULL);

    set_idx_d = set_idx_q;
    if (push) begin
      set_idx_d = (in_last || set_idx_q == IDX_LAST) ? '0 : set_idx_q + IDX_W'(1);
    end

    out_ch_d    = out_ch_q;
    blk_count_d = blk_count_q;
    if (xfer) begin
      out_ch_d    = last_ch  ? '0 : out_ch_q + CH_W'(1);
      blk_count_d = out_last ? '0 : blk_count_q + 16'd1;
    end

    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (push) state_d = ST_EMIT;
      ST_EMIT:  if (pop && count_d == '0) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_EMPTY;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      set_idx_q   <= '0;
      out_ch_q    <= '0;
      blk_count_q <= '0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      set_idx_q   <= set_idx_d;
      out_ch_q    <= out_ch_d;
      blk_count_q <= blk_count_d;
      in_ready_q  <= in_ready_d;
    end
  end

  // Storage needs no reset: entries are only read while counted as occupied.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data_q[wr_ptr_q] <= in_data;
      mem_last_q[wr_ptr_q] <= in_last;
      mem_skip_q[wr_ptr_q] <= wr_skip;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_ch    = out_ch_q;
  assign blk_count = blk_count_q;

endmodule
